// File: rtl/glitch_filter_pkg.sv
// Shared constants and helpers for the multi-channel glitch filter.
package glitch_filter_pkg;

  // Default largest programmable stable width, in cycles.
  localparam int DEF_MAX_WIDTH = 15;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of the configuration inputs and of each stability counter.
  localparam int CW = clog2(DEF_MAX_WIDTH + 1);

  // Effective width: 0 behaves like 1, anything above max_w saturates.
  function automatic int eff_width(input int cfg, input int max_w = DEF_MAX_WIDTH);
    if (cfg <= 0) begin
      return 1;
    end else if (cfg > max_w) begin
      return max_w;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/glitch_filter_chan.sv
// One filter channel: input synchroniser, stability counter and
// registered level / event outputs.
module glitch_filter_chan
  import glitch_filter_pkg::*;
#(
  parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
  parameter int CNT_W       = CW,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] Cfg_Rise_Width,
  input  logic [CNT_W-1:0] Cfg_Fall_Width,
  input  logic             Sig_In,
  output logic             Sig_Out,
  output logic             Rise_Pulse,
  output logic             Fall_Pulse,
  output logic             Glitch_Pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_count;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_glitch;

  logic                   w_s;
  logic [CNT_W-1:0]       w_cfg;
  logic [CNT_W-1:0]       w_eff;

  // Synchronised level and the width that applies to the level being seen now.
  always_comb begin
    w_s   = r_sync[SYNC_STAGES-1];
    w_cfg = w_s ? Cfg_Rise_Width : Cfg_Fall_Width;
    w_eff = CNT_W'(eff_width(int'(w_cfg), MAX_WIDTH));
  end

  // Synchroniser shift, stability counting and edge/glitch decisions.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync   <= {SYNC_STAGES{RESET_LEVEL}};
      r_out    <= RESET_LEVEL;
      r_count  <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], Sig_In};
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
      if (w_s == r_out) begin
        // Excursion collapsed before reaching the width: reject it.
        if (r_count != '0) begin
          r_count  <= '0;
          r_glitch <= 1'b1;
        end
      end else if (r_count >= (w_eff - CNT_W'(1))) begin
        // Stable long enough (>= so a shrunk width commits at once).
        r_out   <= w_s;
        r_count <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        // count stays below w_eff-1 <= MAX_WIDTH-1, so it cannot wrap.
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign Sig_Out      = r_out;
  assign Rise_Pulse   = r_rise;
  assign Fall_Pulse   = r_fall;
  assign Glitch_Pulse = r_glitch;

endmodule

// File: rtl/glitch_filter_multi.sv
// Multi-channel deglitch/debounce filter; all channels share the
// run-time rise and fall widths.
module glitch_filter_multi
  import glitch_filter_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b1,
  localparam int CNT_W      = clog2(MAX_WIDTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CNT_W-1:0]    Cfg_Rise_Width,
  input  logic [CNT_W-1:0]    Cfg_Fall_Width,
  input  logic [CHANNELS-1:0] Sig_In,
  output logic [CHANNELS-1:0] Sig_Out,
  output logic [CHANNELS-1:0] Rise_Pulse,
  output logic [CHANNELS-1:0] Fall_Pulse,
  output logic [CHANNELS-1:0] Glitch_Pulse
);

  // One independent filter per input line.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    glitch_filter_chan #(
      .MAX_WIDTH   (MAX_WIDTH),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .CLK            (CLK),
      .RST            (RST),
      .Cfg_Rise_Width (Cfg_Rise_Width),
      .Cfg_Fall_Width (Cfg_Fall_Width),
      .Sig_In         (Sig_In[gi]),
      .Sig_Out        (Sig_Out[gi]),
      .Rise_Pulse     (Rise_Pulse[gi]),
      .Fall_Pulse     (Fall_Pulse[gi]),
      .Glitch_Pulse   (Glitch_Pulse[gi])
    );
  end

endmodule

// File: tb/tb_glitch_filter_multi.sv
// Scoreboard bench for glitch_filter_multi: stimulus pushes expected
// events (cycle, pulses, level), a monitor pops them when pulses appear.
module tb_glitch_filter_multi;

  logic       CLK;
  logic       RST;
  logic [3:0] Cfg_Rise_Width;
  logic [3:0] Cfg_Fall_Width;
  logic [1:0] Sig_In;
  logic [1:0] Sig_Out;
  logic [1:0] Rise_Pulse;
  logic [1:0] Fall_Pulse;
  logic [1:0] Glitch_Pulse;

  glitch_filter_multi #(
    .CHANNELS    (2),
    .MAX_WIDTH   (15),
    .SYNC_STAGES (2),
    .RESET_LEVEL (1'b1)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Cfg_Rise_Width (Cfg_Rise_Width),
    .Cfg_Fall_Width (Cfg_Fall_Width),
    .Sig_In         (Sig_In),
    .Sig_Out        (Sig_Out),
    .Rise_Pulse     (Rise_Pulse),
    .Fall_Pulse     (Fall_Pulse),
    .Glitch_Pulse   (Glitch_Pulse)
  );

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] glitch;
    logic [1:0] lvl;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count rising edges; an output committed at edge k is seen with cyc == k.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event dcyc edges after now (now = just after an edge).
  task automatic push(input int dcyc, input logic [1:0] r, input logic [1:0] f,
                      input logic [1:0] g, input logic [1:0] l);
    exp_t e;
    e.cyc = cyc + dcyc; e.rise = r; e.fall = f; e.glitch = g; e.lvl = l;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: any pulse is a transaction and must match the queue head.
  always @(negedge CLK) begin
    if ((|Rise_Pulse) || (|Fall_Pulse) || (|Glitch_Pulse)) begin
      $display("event cyc=%0d rise=%b fall=%b glitch=%b out=%b",
               cyc, Rise_Pulse, Fall_Pulse, Glitch_Pulse, Sig_Out);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got rise=%b fall=%b glitch=%b expected none (cycle %0d)",
                 Rise_Pulse, Fall_Pulse, Glitch_Pulse, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("rise_pulse", {30'd0, Rise_Pulse}, {30'd0, e.rise});
        chk("fall_pulse", {30'd0, Fall_Pulse}, {30'd0, e.fall});
        chk("glitch_pulse", {30'd0, Glitch_Pulse}, {30'd0, e.glitch});
        chk("sig_out", {30'd0, Sig_Out}, {30'd0, e.lvl});
      end
    end
  end

  initial begin
    RST = 1'b1;
    Sig_In = 2'b00;
    Cfg_Rise_Width = 4'd3;
    Cfg_Fall_Width = 4'd5;

    // 1. Reset with inputs low: idle-high outputs, then both fall 2+5 later.
    tick(2);
    chk("reset_sig_out", {30'd0, Sig_Out}, 32'd3);
    chk("reset_pulses", {26'd0, Rise_Pulse, Fall_Pulse, Glitch_Pulse}, 32'd0);
    RST = 1'b0;
    push(7, 2'b00, 2'b11, 2'b00, 2'b00);
    tick(10);

    // 2. Rise on ch0 after 2+3 edges; ch1 stays low.
    Sig_In = 2'b01;
    push(5, 2'b01, 2'b00, 2'b00, 2'b01);
    tick(8);
    chk("rise_level", {30'd0, Sig_Out}, 32'd1);

    // 3. Back low, then a 2-cycle high pulse: counts 1,2 then rejected at +5.
    Sig_In = 2'b00;
    push(7, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(10);
    Sig_In = 2'b01;
    push(5, 2'b00, 2'b00, 2'b01, 2'b00);
    tick(2);
    Sig_In = 2'b00;
    tick(8);
    chk("glitch_level", {30'd0, Sig_Out}, 32'd0);
    // 3-cycle pulse reaches W=3: rise at +5, fall 2+5 after the drop.
    Sig_In = 2'b01;
    push(5, 2'b01, 2'b00, 2'b00, 2'b01);
    push(10, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(3);
    Sig_In = 2'b00;
    tick(12);

    // 4a. Rise width 0 acts as 1: rise 2+1 edges after the change.
    Cfg_Rise_Width = 4'd0;
    Sig_In = 2'b01;
    push(3, 2'b01, 2'b00, 2'b00, 2'b01);
    tick(6);
    Sig_In = 2'b00;
    push(7, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(10);
    // 4b. Maximum width 15: rise 2+15 edges after the change.
    Cfg_Rise_Width = 4'd15;
    Sig_In = 2'b01;
    push(17, 2'b01, 2'b00, 2'b00, 2'b01);
    tick(20);
    Cfg_Rise_Width = 4'd3;
    // 4c. Fall pending with count=3 after 5 edges; width 5->1 commits next edge.
    Sig_In = 2'b00;
    tick(5);
    chk("pending_fall_level", {30'd0, Sig_Out}, 32'd1);
    Cfg_Fall_Width = 4'd1;
    push(1, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(4);
    Cfg_Fall_Width = 4'd5;

    // 5. Both channels rise together.
    Sig_In = 2'b11;
    push(5, 2'b11, 2'b00, 2'b00, 2'b11);
    tick(8);

    // 6. Reset while a fall is pending at count=2: no pulse, count restarts.
    Sig_In = 2'b00;
    tick(4);
    RST = 1'b1;
    tick(1);
    chk("midreset_sig_out", {30'd0, Sig_Out}, 32'd3);
    chk("midreset_pulses", {26'd0, Rise_Pulse, Fall_Pulse, Glitch_Pulse}, 32'd0);
    RST = 1'b0;
    push(7, 2'b00, 2'b11, 2'b00, 2'b00);
    tick(5);
    chk("restart_level", {30'd0, Sig_Out}, 32'd3);
    tick(8);
    chk("final_level", {30'd0, Sig_Out}, 32'd0);

    // Every expected event must have been seen.
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
